// File: rtl/cskipa_pkg.sv
// Shared elaboration helpers for the pipelined carry-skip adder.
package cskipa_pkg;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Number of skip blocks covering the operand.
   function automatic int num_blocks(input int width, input int block);
      return ceil_div(width, block);
   endfunction

   // Blocks owned by each pipeline stage.
   function automatic int blocks_per_stage(input int nb, input int stages);
      return ceil_div(nb, stages);
   endfunction

   // Width of the most significant block; a full block when WIDTH divides evenly.
   function automatic int last_bw(input int width, input int block);
      return ((width % block) == 0) ? block : (width % block);
   endfunction

endpackage

// File: rtl/cskip_block.sv
// One carry-skip block: ripple sum plus a skip mux on the all-propagate case.
module cskip_block #(
   parameter int BW = 4
) (
   input  logic [BW-1:0] a,
   input  logic [BW-1:0] b,
   input  logic          cin,
   output logic [BW-1:0] sum,
   output logic          cout
);

   // Ripple through the block, then bypass the chain when every bit propagates.
   always_comb begin
      logic rc;
      sum = '0;
      rc  = cin;
      for (int i = 0; i < BW; i++) begin
         sum[i] = a[i] ^ b[i] ^ rc;
         rc     = (a[i] & b[i]) | (rc & (a[i] ^ b[i]));
      end
      cout = (&(a ^ b)) ? cin : rc;
   end

endmodule

// File: rtl/cskipa_pipe.sv
// Pipelined carry-skip adder with valid/ready handshake and full backpressure.
module cskipa_pipe
   import cskipa_pkg::*;
#(
   parameter int WIDTH  = 25,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add_term1,
   input  logic [WIDTH-1:0] i_add_term2,
   input  logic             i_cin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int NB  = num_blocks(WIDTH, BLOCK);
   localparam int BPS = blocks_per_stage(NB, STAGES);
   localparam int LBW = last_bw(WIDTH, BLOCK);

   // Carry into the next unresolved block, sum bits resolved so far, operands.
   typedef struct packed {
      logic             c;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } stage_t;

   stage_t            dq [STAGES];   // stage registers; the last one drives the outputs
   stage_t            so [STAGES];   // combinational result of each stage's blocks
   logic [STAGES-1:0] vld_q;
   logic [STAGES:0]   vld_pipe;      // [0] is the incoming valid, [k+1] is stage k
   logic [STAGES:0]   ld;            // ld[k]: stage k register may load this cycle
   logic              ovf_q;
   logic              ovf_n;

   assign vld_pipe = {vld_q, i_valid};

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      // Stages past the last block just forward their contents.
      localparam int LO  = min_i(k * BPS, NB);
      localparam int HI  = min_i((k + 1) * BPS, NB);
      localparam int LOB = LO * BLOCK;
      localparam int HIB = min_i(HI * BLOCK, WIDTH);

      stage_t           si;
      logic [WIDTH-1:0] bs;
      logic             c_out;

      if (k == 0) begin : g_in
         assign si = {i_cin, {WIDTH{1'b0}}, i_add_term1, i_add_term2};
      end else begin : g_reg
         assign si = dq[k-1];
      end

      // Sum bits outside this stage's range are still zero here, so OR-merging is exact.
      for (genvar i = 0; i < WIDTH; i++) begin : g_zero
         if (i < LOB || i >= HIB) begin : g_z
            assign bs[i] = 1'b0;
         end
      end

      for (genvar j = LO; j < HI; j++) begin : g_blk
         localparam int BW = (j == NB - 1) ? LBW : BLOCK;
         localparam int BL = j * BLOCK;
         logic ci;
         logic co;
         if (j == LO) begin : g_c0
            assign ci = si.c;
         end else begin : g_cn
            assign ci = g_blk[j-1].co;
         end
         cskip_block #(.BW(BW)) u_blk (
            .a    (si.a[BL +: BW]),
            .b    (si.b[BL +: BW]),
            .cin  (ci),
            .sum  (bs[BL +: BW]),
            .cout (co)
         );
      end

      if (HI > LO) begin : g_cy
         assign c_out = g_blk[HI-1].co;
      end else begin : g_cp
         assign c_out = si.c;
      end

      assign so[k] = {c_out, si.sum | bs, si.a, si.b};
   end

   assign ovf_n = (so[STAGES-1].a[WIDTH-1] & so[STAGES-1].b[WIDTH-1] & ~so[STAGES-1].sum[WIDTH-1]) |
                  (~so[STAGES-1].a[WIDTH-1] & ~so[STAGES-1].b[WIDTH-1] & so[STAGES-1].sum[WIDTH-1]);

   // Ready chain from the consumer back to the producer: a stage loads when empty or draining.
   always_comb begin
      ld         = '0;
      ld[STAGES] = i_ready;
      for (int k = STAGES - 1; k >= 0; k--)
         ld[k] = !vld_pipe[k+1] || ld[k+1];
   end

   assign o_ready = ld[0];

   // Stage registers: shift forward where allowed, hold otherwise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++)
            dq[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               vld_q[k] <= vld_pipe[k];
               if (vld_pipe[k])
                  dq[k] <= so[k];
            end
         end
         if (ld[STAGES-1] && vld_pipe[STAGES-1])
            ovf_q <= ovf_n;
      end
   end

   assign o_valid = vld_pipe[STAGES];
   assign o_sum   = dq[STAGES-1].sum;
   assign o_cout  = dq[STAGES-1].c;
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_cskipa_pipe.sv
// Randomized bench for cskipa_pipe against a plain A+B+cin reference with a FIFO scoreboard.
module tb_cskipa_pipe;

   localparam int W  = 25;
   localparam int BK = 4;
   localparam int ST = 2;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_add_term1;
   logic [W-1:0] i_add_term2;
   logic         i_cin;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_sum;
   logic         o_cout;
   logic         o_ovf;

   int n_vec = 0;
   int n_err = 0;

   logic [W+1:0] q [$];   // expected {ovf, cout, sum} in order of acceptance

   cskipa_pipe #(.WIDTH(W), .BLOCK(BK), .STAGES(ST)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_add_term1 (i_add_term1),
      .i_add_term2 (i_add_term2),
      .i_cin       (i_cin),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_sum       (o_sum),
      .o_cout      (o_cout),
      .o_ovf       (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   // Reference: widen, add, and read overflow off the sign bits.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] full;
      logic       ovf;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return {ovf, full};
   endfunction

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: watch transfers mid-cycle, ahead of the edge that commits them.
   logic         held = 1'b0;
   logic [W+1:0] held_val;
   always @(negedge i_clk) begin
      if (i_rst) begin
         q.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid", o_valid, 1'b1);
            chk("stall_hold", {o_ovf, o_cout, o_sum}, held_val);
         end
         if (o_valid) chk("valid_has_item", q.size() != 0, 1'b1);
         if (o_valid && i_ready && q.size() != 0)
            chk("result", {o_ovf, o_cout, o_sum}, q.pop_front());
         if (i_valid && o_ready)
            q.push_back(model(i_add_term1, i_add_term2, i_cin));
         held     = o_valid && !i_ready;
         held_val = {o_ovf, o_cout, o_sum};
      end
   end

   task automatic drive_rnd();
      i_add_term1 = rnd_op();
      i_add_term2 = rnd_op();
      i_cin       = 1'($urandom_range(0, 1));
   endtask

   // Single pair into an empty pipe; result must appear exactly ST cycles after presentation.
   task automatic one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec, input logic eo);
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_add_term1 = a; i_add_term2 = b; i_cin = c;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      for (int i = 1; i < ST; i++) begin
         chk("lat_early", o_valid, 1'b0);
         @(posedge i_clk); #1;
      end
      chk("lat_valid", o_valid, 1'b1);
      chk("dir_sum", o_sum, es);
      chk("dir_cout", o_cout, ec);
      chk("dir_ovf", o_ovf, eo);
      @(posedge i_clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      while ((q.size() != 0 || o_valid) && n < 50) begin
         @(posedge i_clk); #1;
         n++;
      end
      chk("drain_empty", q.size(), 0);
      chk("drain_valid", o_valid, 1'b0);
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
      i_add_term1 = '0; i_add_term2 = '0; i_cin = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;

      chk("rst_valid", o_valid, 1'b0);
      chk("rst_sum", o_sum, '0);
      chk("rst_cout", o_cout, 1'b0);
      chk("rst_ovf", o_ovf, 1'b0);
      chk("rst_ready", o_ready, 1'b1);

      // Pin the reference itself.
      chk("model_carry", model(25'h1FFFFFF, 25'h0, 1'b1), {1'b0, 1'b1, 25'h0000000});
      chk("model_ovf", model(25'h0FFFFFF, 25'h1, 1'b0), {1'b1, 1'b0, 25'h1000000});
      chk("model_neg", model(25'h1000000, 25'h1000000, 1'b0), {1'b1, 1'b1, 25'h0000000});

      one(25'h1FFFFFF, 25'h0000000, 1'b1, 25'h0000000, 1'b1, 1'b0);
      one(25'h0FFFFFF, 25'h0000001, 1'b0, 25'h1000000, 1'b0, 1'b1);
      one(25'h1000000, 25'h1000000, 1'b0, 25'h0000000, 1'b1, 1'b1);
      one(25'h0000123, 25'h0000456, 1'b1, 25'h000057A, 1'b0, 1'b0);
      one(25'h0F0F0F0, 25'h00F0F0F, 1'b1, 25'h1000000, 1'b0, 1'b1);

      // Back-to-back throughput.
      i_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         i_valid = 1'b1;
         drive_rnd();
         chk("tput_ready", o_ready, 1'b1);
         if (i >= ST) chk("tput_valid", o_valid, 1'b1);
         @(posedge i_clk); #1;
      end
      drain();

      // Backpressure: fill while the consumer stalls, then release.
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         i_valid = 1'b1;
         drive_rnd();
         @(posedge i_clk); #1;
      end
      i_valid = 1'b0;
      chk("bp_ready", o_ready, 1'b0);
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_depth", q.size(), ST);
      repeat (2) @(posedge i_clk);
      #1 drain();

      // Reset with two pairs in flight.
      i_ready = 1'b0;
      i_valid = 1'b1;
      drive_rnd();
      @(posedge i_clk); #1;
      drive_rnd();
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_ready = 1'b1;
      chk("mid_rst_valid", o_valid, 1'b0);
      chk("mid_rst_sum", o_sum, '0);
      chk("mid_rst_cout", o_cout, 1'b0);
      chk("mid_rst_ovf", o_ovf, 1'b0);
      one(25'h0000FFF, 25'h0000001, 1'b0, 25'h0001000, 1'b0, 1'b0);

      // Random valid/ready traffic.
      for (int i = 0; i < 3000; i++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 3) != 0);
         drive_rnd();
         @(posedge i_clk); #1;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
